alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the team's 4-bit combinational ALU. It supports any power-of-two operand width and adds a valid/ready handshake on both sides, a two-stage pipeline with backpressure, and registered status flags. It also carries a persistent accumulator and carry register, so multi-word arithmetic (ADC) and accumulate chains run back-to-back at full throughput. It sits between an operand issuer (sequencer/datapath controller) and a result consumer.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; power of two, ≥ 4. SW = log2(WIDTH) is derived internally.

Ports:
- clk  in  1  single clock for all state; rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- in_op  in  4  opcode (see Operation).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; for shifts, in_b[SW-1:0] is the shift amount.
- in_acc_sel  in  1  1 = use accumulator as operand A instead of in_a.
- in_acc_wr  in  1  1 = write the result into the accumulator on completion.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_y  out  WIDTH  result.
- out_flags  out  4  {N, Z, C, V} for out_y.
- out_acc  out  WIDTH  current accumulator value (observation only).

## Operation
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NAND
  - 6 NOR
  - 7 XNOR
  - 8 SHL a<<amt (logical)
  - 9 SHR a>>amt (logical)
  - A INC a+1
  - B DEC a−1
  - C PASS a
  - D ADC a+b+carry_reg
  - E NOT a
  - F CMP: a−b with flags; accumulator is never written, even if in_acc_wr = 1.
- Stage 1 (S1) registers op, a, b, acc_sel, acc_wr on acceptance.
- Computation is combinational from S1 plus the live acc/carry_reg. The result is registered into stage 2 (S2) when S1 advances.
- acc and carry_reg update at that same edge. Every op therefore sees the effects of all earlier ops, with no forwarding needed and no hazard.
- All arithmetic is WIDTH bits; results wrap modulo 2^WIDTH.
- Flags:
  - Z = (y == 0).
  - N = y[WIDTH−1].
  - C:
    - ADD/INC/ADC: carry out.
    - SUB/DEC/CMP: borrow (1 when unsigned a < subtrahend).
    - SHL: last bit shifted out of the MSB side.
    - SHR: last bit shifted out of the LSB side.
    - Shift by 0: C = 0.
    - Logic/PASS/NOT: C = 0.
  - V: signed overflow for ADD, SUB, INC, DEC, ADC, CMP; 0 otherwise.
- carry_reg updates only for opcodes 0, 1, 8, 9, A, B, D, F; other ops leave it unchanged.
- Operand A = acc when in_acc_sel, else in_a.

## Timing
- Reset (rst_n low, asynchronous): S1/S2 valid = 0, out_valid = 0, out_y = 0, out_flags = 0, acc = 0, carry_reg = 0, in_ready = 1 after release. In-flight ops are discarded, including on reset mid-operation.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - S1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational; full throughput).
- Latency: op accepted at edge k produces out_valid = 1 after edge k+1, i.e. visible 2 cycles after the accept cycle when unstalled.
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure:
  - out_ready low holds out_y/out_flags stable.
  - S1 fills, then in_ready drops.
  - No loss, duplication or reordering.
- A simultaneous out-transfer and S1 advance in the same cycle is legal; S2 reloads without a bubble.
- in_* are ignored when !in_valid || !in_ready; acc/carry_reg change only at S1→S2 edges.

## Test plan
- WIDTH=8, ADD 0xF0+0x20 → out_y=0x10, flags N=0 Z=0 C=1 V=0, out_valid 2 cycles after accept.
- SUB 0x80−0x01 → 0x7F, V=1 C=0.
- SUB 0x01−0x02 → 0xFF, N=1 C=1.
- CMP 0x05−0x05 with in_acc_wr=1 → Z=1, acc unchanged.
- Back-to-back ADD 0xFF+0x01 (→0x00, Z=1 C=1) then ADC 0x00+0x00 → 0x01, C=0, consecutive cycles.
- Accumulate chain: PASS 0x05 with acc_wr, then 3× INC with acc_sel+acc_wr streamed on consecutive cycles → outputs 0x05, 0x06, 0x07, 0x08; out_acc=0x08.
- Shifts:
  - SHL 0x81 by 1 → 0x02, C=1.
  - SHR 0x81 by 0 → 0x81, C=0.
  - SHR 0x03 by 9 (amt=1) → 0x01, C=1.
- Backpressure/reset:
  - Stream 3 ops with out_ready low 5 cycles → in_ready low after 2 accepted, results delivered in order once out_ready=1.
  - Assert rst_n mid-stream → out_valid=0 and out_acc=0 immediately (async).

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with persistent accumulator and carry register
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc_sel,
    input  logic             in_acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] out_acc
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_NAND = 4'h5, OP_NOR  = 4'h6, OP_XNOR = 4'h7,
        OP_SHL  = 4'h8, OP_SHR  = 4'h9, OP_INC  = 4'hA, OP_DEC  = 4'hB,
        OP_PASS = 4'hC, OP_ADC  = 4'hD, OP_NOT  = 4'hE, OP_CMP  = 4'hF
    } op_e;

    op_e              s1_op_q;
    logic             s1_valid_q, s1_acc_sel_q, s1_acc_wr_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             out_valid_q, carry_q;
    logic [WIDTH-1:0] y_q, acc_q;
    logic [3:0]       flags_q;

    logic             s2_free, s1_adv, accept;
    logic [WIDTH-1:0] opa, opnd, y_d;
    logic [WIDTH:0]   arith, shl_ext, shr_ext;
    logic [SW-1:0]    amt;
    logic             sub, cin, arith_v, c_d, v_d, carry_wr;
    logic [3:0]       flags_d;

    assign s2_free   = !out_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    assign in_ready  = !s1_valid_q || s2_free;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_y     = y_q;
    assign out_flags = flags_q;
    assign out_acc   = acc_q;

    // Operand A reads the live accumulator, so every op sees all earlier results.
    always_comb begin
        opa  = s1_acc_sel_q ? acc_q : s1_a_q;
        amt  = s1_b_q[SW-1:0];
        opnd = s1_b_q;
        sub  = 1'b0;
        cin  = 1'b0;
        case (s1_op_q)
            OP_SUB, OP_CMP: sub = 1'b1;
            OP_INC:         opnd = WIDTH'(1);
            OP_DEC: begin
                opnd = WIDTH'(1);
                sub  = 1'b1;
            end
            OP_ADC:         cin = carry_q;
            default: ;
        endcase
        arith   = sub ? ({1'b0, opa} - {1'b0, opnd})
                      : ({1'b0, opa} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin});
        arith_v = (sub ? (opa[MSB] != opnd[MSB]) : (opa[MSB] == opnd[MSB]))
                  && (arith[MSB] != opa[MSB]);
        // Extra bit on each shifter catches the last bit shifted out (0 for amount 0).
        shl_ext = {1'b0, opa} << amt;
        shr_ext = {opa, 1'b0} >> amt;

        y_d      = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        carry_wr = 1'b1;
        case (s1_op_q)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_CMP: begin
                y_d = arith[MSB:0];
                c_d = arith[WIDTH];
                v_d = arith_v;
            end
            OP_SHL: begin
                y_d = shl_ext[MSB:0];
                c_d = shl_ext[WIDTH];
            end
            OP_SHR: begin
                y_d = shr_ext[WIDTH:1];
                c_d = shr_ext[0];
            end
            OP_AND:  begin y_d = opa & s1_b_q;    carry_wr = 1'b0; end
            OP_OR:   begin y_d = opa | s1_b_q;    carry_wr = 1'b0; end
            OP_XOR:  begin y_d = opa ^ s1_b_q;    carry_wr = 1'b0; end
            OP_NAND: begin y_d = ~(opa & s1_b_q); carry_wr = 1'b0; end
            OP_NOR:  begin y_d = ~(opa | s1_b_q); carry_wr = 1'b0; end
            OP_XNOR: begin y_d = ~(opa ^ s1_b_q); carry_wr = 1'b0; end
            OP_PASS: begin y_d = opa;             carry_wr = 1'b0; end
            OP_NOT:  begin y_d = ~opa;            carry_wr = 1'b0; end
            default: carry_wr = 1'b0;
        endcase
        flags_d = {y_d[MSB], (y_d == '0), c_d, v_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_ADD;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_acc_sel_q <= 1'b0;
            s1_acc_wr_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            y_q          <= '0;
            flags_q      <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q   <= 1'b1;
                s1_op_q      <= op_e'(in_op);
                s1_a_q       <= in_a;
                s1_b_q       <= in_b;
                s1_acc_sel_q <= in_acc_sel;
                s1_acc_wr_q  <= in_acc_wr;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                out_valid_q <= 1'b1;
                y_q         <= y_d;
                flags_q     <= flags_d;
                if (carry_wr)
                    carry_q <= c_d;
                if (s1_acc_wr_q && (s1_op_q != OP_CMP))
                    acc_q <= y_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = 4'h0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_acc_sel = 1'b0;
    logic       in_acc_wr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic [3:0] out_flags;
    logic [7:0] out_acc;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_acc_sel(in_acc_sel), .in_acc_wr(in_acc_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_flags(out_flags), .out_acc(out_acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { int y; int f; } res_t;
    res_t exp_q[$];
    int   obs_y[$];
    int   obs_f[$];
    int   m_acc = 0;
    int   m_carry = 0;

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int ovf(input int r);
        return (r > 127 || r < -128) ? 1 : 0;
    endfunction

    task automatic model_accept(input int op, input int ain, input int b, input int sel, input int wr);
        int a, y, c, v, amt, upd;
        res_t e;
        a = (sel != 0) ? m_acc : ain;
        amt = b % 8;
        c = 0; v = 0; upd = 1; y = 0;
        case (op)
            0:  begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0; v = ovf(sx(a) + sx(b)); end
            1, 15: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; v = ovf(sx(a) - sx(b)); end
            2:  begin y = a & b; upd = 0; end
            3:  begin y = a | b; upd = 0; end
            4:  begin y = a ^ b; upd = 0; end
            5:  begin y = 255 - (a & b); upd = 0; end
            6:  begin y = 255 - (a | b); upd = 0; end
            7:  begin y = 255 - (a ^ b); upd = 0; end
            8:  begin y = (a * (1 << amt)) % 256; c = (amt == 0) ? 0 : (a / (1 << (8 - amt))) % 2; end
            9:  begin y = a / (1 << amt); c = (amt == 0) ? 0 : (a / (1 << (amt - 1))) % 2; end
            10: begin y = (a + 1) % 256; c = (a == 255) ? 1 : 0; v = ovf(sx(a) + 1); end
            11: begin y = (a + 255) % 256; c = (a == 0) ? 1 : 0; v = ovf(sx(a) - 1); end
            12: begin y = a; upd = 0; end
            13: begin
                y = (a + b + m_carry) % 256;
                c = (a + b + m_carry > 255) ? 1 : 0;
                v = ovf(sx(a) + sx(b) + m_carry);
            end
            default: begin y = 255 - a; upd = 0; end
        endcase
        e.y = y;
        e.f = ((y >= 128) ? 8 : 0) + ((y == 0) ? 4 : 0) + 2 * c + v;
        exp_q.push_back(e);
        if (upd != 0) m_carry = c;
        if (wr != 0 && op != 15) m_acc = y;
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_acc = 0;
            m_carry = 0;
        end else begin
            if (out_valid && out_ready) begin
                obs_y.push_back(int'(out_y));
                obs_f.push_back(int'(out_flags));
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("model_y", 32'(out_y), e.y);
                    check("model_flags", 32'(out_flags), e.f);
                end
            end
            if (in_valid && in_ready)
                model_accept(int'(in_op), int'(in_a), int'(in_b), int'(in_acc_sel), int'(in_acc_wr));
        end
    end

    task automatic send(input int op, input int a, input int b, input bit sel, input bit wr, input bit rr);
        in_valid = 1'b1;
        in_op = 4'(op);
        in_a = 8'(a);
        in_b = 8'(b);
        in_acc_sel = sel;
        in_acc_wr = wr;
        if (rr) out_ready = ($urandom_range(0, 3) != 0);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 200) begin
                check("accept_timeout", 32'(in_ready), 1);
                break;
            end
            @(posedge clk); #1;
            if (rr) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            if (!out_valid && exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic expect_obs(input string tag, input int idx, input int y, input int f);
        if (idx >= obs_y.size()) begin
            check({tag, "_missing"}, obs_y.size(), idx + 1);
        end else begin
            check({tag, "_y"}, obs_y[idx], y);
            check({tag, "_flags"}, obs_f[idx], f);
        end
    endtask

    // op, a, b, acc_sel, acc_wr, expected y, expected flags {N,Z,C,V}
    int d_tab[13][7] = '{
        '{1,  'h80, 'h01, 0, 0, 'h7F, 'h1},
        '{1,  'h01, 'h02, 0, 0, 'hFF, 'hA},
        '{12, 'h33, 'h00, 0, 1, 'h33, 'h0},
        '{15, 'h05, 'h05, 0, 1, 'h00, 'h4},
        '{0,  'hFF, 'h01, 0, 0, 'h00, 'h6},
        '{13, 'h00, 'h00, 0, 0, 'h01, 'h0},
        '{12, 'h05, 'h00, 0, 1, 'h05, 'h0},
        '{10, 'h00, 'h00, 1, 1, 'h06, 'h0},
        '{10, 'h00, 'h00, 1, 1, 'h07, 'h0},
        '{10, 'h00, 'h00, 1, 1, 'h08, 'h0},
        '{8,  'h81, 'h01, 0, 0, 'h02, 'h2},
        '{9,  'h81, 'h00, 0, 0, 'h81, 'h8},
        '{9,  'h03, 'h09, 0, 0, 'h01, 'h2}
    };

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_out_flags", 32'(out_flags), 0);
        check("rst_out_acc", 32'(out_acc), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        send(0, 'hF0, 'h20, 0, 0, 0);
        in_valid = 1'b0;
        check("lat_k1_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_k2_valid", 32'(out_valid), 1);
        check("lat_add_y", 32'(out_y), 'h10);
        check("lat_add_flags", 32'(out_flags), 'h2);
        drain();

        base = obs_y.size();
        for (int i = 0; i < 4; i++)
            send(d_tab[i][0], d_tab[i][1], d_tab[i][2], d_tab[i][3] != 0, d_tab[i][4] != 0, 0);
        drain();
        check("cmp_acc_kept", 32'(out_acc), 'h33);
        for (int i = 4; i < 13; i++)
            send(d_tab[i][0], d_tab[i][1], d_tab[i][2], d_tab[i][3] != 0, d_tab[i][4] != 0, 0);
        drain();
        check("chain_acc", 32'(out_acc), 'h08);
        for (int i = 0; i < 13; i++)
            expect_obs($sformatf("dir%0d", i), base + i, d_tab[i][5], d_tab[i][6]);

        base = obs_y.size();
        out_ready = 1'b0;
        send(0, 1, 1, 0, 0, 0);
        send(0, 2, 2, 0, 0, 0);
        in_valid = 1'b1; in_op = 4'h4; in_a = 8'hF0; in_b = 8'h0F;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_y", 32'(out_y), 2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4, 'hF0, 'h0F, 0, 0, 0);
        drain();
        expect_obs("bp0", base, 2, 0);
        expect_obs("bp1", base + 1, 4, 0);
        expect_obs("bp2", base + 2, 'hFF, 'h8);

        send(12, 'h55, 0, 0, 1, 0);
        send(0, 1, 2, 0, 0, 0);
        check("pre_rst_acc", 32'(out_acc), 'h55);
        check("pre_rst_valid", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_acc", 32'(out_acc), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
        end
        drain();
        check("final_acc", 32'(out_acc), m_acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
